// File: rtl/ps2_tx_pkg.sv
// Shared types and constants for the PS/2 keyboard-event transmitter.
`default_nettype none

package ps2_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        BIT_HI = 3'd2,
        BIT_LO = 3'd3,
        GAP    = 3'd4
    } tx_state_t;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam int         FRAME_BITS = 11;

    // bytes[7:0] is sent first; len is 1..3
    typedef struct packed {
        logic [1:0]  len;
        logic [23:0] bytes;
    } ev_bytes_t;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    function automatic ev_bytes_t expand_event(input logic [9:0] ev);
        ev_bytes_t r;
        int        n;
        r = '0;
        n = 0;
        if (ev[8]) begin
            r.bytes[n*8 +: 8] = PS2_EXT;
            n++;
        end
        if (!ev[9]) begin
            r.bytes[n*8 +: 8] = PS2_BRK;
            n++;
        end
        r.bytes[n*8 +: 8] = ev[7:0];
        r.len = 2'(n + 1);
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_tx_fifo.sv
// Byte FIFO with wrap-bit pointers; push and pop may occur in the same cycle.
`default_nettype none

module ps2_tx_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          push_i,
    input  logic [7:0]                    data_i,
    input  logic                          pop_i,
    output logic [7:0]                    data_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   free_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_q;
    logic [AW:0] rd_q;

    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign free_o  = (AW+1)'(FIFO_DEPTH) - (wr_q - rd_q);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i && !full_o) wr_q <= wr_q + 1'b1;
            if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

`default_nettype wire

// File: rtl/ps2_key_tx.sv
// Turns key events into PS/2 device-to-host frames (E0/F0 prefixes, odd parity).
// Optional host inhibit input enabled by macro PS2_KEY_TX_INHIBIT_EN.
`default_nettype none

module ps2_key_tx
    import ps2_tx_pkg::*;
#(
    parameter int CLK_DIV    = 1000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        CLK50MHZ,
    input  logic        COCO_RESET_N,
    input  logic [10:0] ps2_key,
`ifdef PS2_KEY_TX_INHIBIT_EN
    input  logic        ps2_inhibit,
`endif
    output logic        ps2_clk,
    output logic        ps2_data,
    output logic        busy,
    output logic        overflow
);

    localparam int FAW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW  = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(2 * CLK_DIV - 1);

    logic inhibit;
`ifdef PS2_KEY_TX_INHIBIT_EN
    assign inhibit = ps2_inhibit;
`else
    assign inhibit = 1'b0;
`endif

    logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]     fifo_dout;
    logic [FAW-1:0] fifo_free;

    // ---------------- event capture and atomic enqueue ----------------
    logic        armed_q, tog_q;
    logic        pend_vld_q, pend_vld_d;
    logic [9:0]  pend_q, pend_d;
    logic [23:0] ebuf_q, ebuf_d;
    logic [1:0]  ecnt_q, ecnt_d;
    logic        ovf_q, ovf_d;
    logic        ev_det, take;
    logic [9:0]  take_key;
    ev_bytes_t   exp_ev;

    assign ev_det = armed_q && (ps2_key[10] != tog_q);

    always_comb begin
        pend_vld_d = pend_vld_q;
        pend_d     = pend_q;
        ebuf_d     = ebuf_q;
        ecnt_d     = ecnt_q;
        ovf_d      = 1'b0;
        fifo_push  = 1'b0;
        take       = 1'b0;
        take_key   = ps2_key[9:0];
        exp_ev     = '0;
        if (ecnt_q != 2'd0) begin
            fifo_push = !fifo_full;
            ebuf_d    = {8'h00, ebuf_q[23:8]};
            ecnt_d    = ecnt_q - 2'd1;
            if (ev_det) begin
                if (pend_vld_q) begin
                    ovf_d = 1'b1;
                end else begin
                    pend_vld_d = 1'b1;
                    pend_d     = ps2_key[9:0];
                end
            end
        end else begin
            if (pend_vld_q) begin
                take       = 1'b1;
                take_key   = pend_q;
                pend_vld_d = ev_det;
                if (ev_det) pend_d = ps2_key[9:0];
            end else if (ev_det) begin
                take = 1'b1;
            end
            if (take) begin
                exp_ev = expand_event(take_key);
                // Only this path pushes, so the free count cannot shrink mid-event.
                if (fifo_free >= FAW'(exp_ev.len)) begin
                    ebuf_d = exp_ev.bytes;
                    ecnt_d = exp_ev.len;
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK50MHZ or negedge COCO_RESET_N) begin
        if (!COCO_RESET_N) begin
            armed_q    <= 1'b0;
            tog_q      <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_q     <= '0;
            ebuf_q     <= '0;
            ecnt_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            armed_q    <= 1'b1;
            tog_q      <= ps2_key[10];
            pend_vld_q <= pend_vld_d;
            pend_q     <= pend_d;
            ebuf_q     <= ebuf_d;
            ecnt_q     <= ecnt_d;
            ovf_q      <= ovf_d;
        end
    end

    ps2_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (CLK50MHZ),
        .rst_ni  (COCO_RESET_N),
        .push_i  (fifo_push),
        .data_i  (ebuf_q[7:0]),
        .pop_i   (fifo_pop),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .free_o  (fifo_free)
    );

    // ---------------- transmit FSM ----------------
    tx_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        bit_q, bit_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic              retry_q, retry_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        frame_d  = frame_q;
        retry_d  = retry_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: if (!fifo_empty && !inhibit) state_d = LOAD;
            LOAD: begin
                fifo_pop = 1'b1;
                frame_d  = {1'b1, odd_parity(fifo_dout), fifo_dout, 1'b0};
                bit_d    = 4'd0;
                cnt_d    = '0;
                state_d  = BIT_HI;
                if (inhibit) begin
                    retry_d = 1'b1;
                    state_d = GAP;
                end
            end
            BIT_HI: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = BIT_LO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BIT_LO: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 4'(FRAME_BITS - 1)) begin
                        state_d = GAP;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        state_d = BIT_HI;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                // The gap only runs while the host lets the clock go.
                if (inhibit) begin
                    cnt_d = '0;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (retry_q) begin
                        retry_d = 1'b0;
                        bit_d   = 4'd0;
                        state_d = BIT_HI;
                    end else if (!fifo_empty) begin
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if ((state_q == BIT_HI || state_q == BIT_LO) && inhibit && bit_q <= 4'd9) begin
            state_d = GAP;
            cnt_d   = '0;
            retry_d = 1'b1;
        end
    end

    always_ff @(posedge CLK50MHZ or negedge COCO_RESET_N) begin
        if (!COCO_RESET_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            frame_q <= '1;
            retry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            retry_q <= retry_d;
        end
    end

    assign ps2_clk  = (state_q != BIT_LO);
    assign ps2_data = (state_q == BIT_HI || state_q == BIT_LO) ? frame_q[bit_q] : 1'b1;
    assign busy     = !fifo_empty || (state_q != IDLE) || (ecnt_q != 2'd0) || pend_vld_q;
    assign overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_tx.sv
// Self-checking bench: decodes the PS/2 lines and compares against an event-level model.
`default_nettype none

module tb_ps2_key_tx;

    localparam int C = 4;
    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] key;
    logic        ps2_clk, ps2_data, busy, overflow;
`ifdef PS2_KEY_TX_INHIBIT_EN
    logic        inh;
`endif

    always #5 clk = ~clk;

    ps2_key_tx #(.CLK_DIV(C), .FIFO_DEPTH(D)) dut (
        .CLK50MHZ     (clk),
        .COCO_RESET_N (rst_n),
        .ps2_key      (key),
`ifdef PS2_KEY_TX_INHIBIT_EN
        .ps2_inhibit  (inh),
`endif
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .busy         (busy),
        .overflow     (overflow)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] exp_q[$];
    int         occ     = 0;
    int         exp_ovf = 0;

    task automatic model_event(input logic [9:0] e);
        logic [7:0] b[$];
        if (e[8])  b.push_back(8'hE0);
        if (!e[9]) b.push_back(8'hF0);
        b.push_back(e[7:0]);
        if (D - occ >= b.size()) begin
            foreach (b[i]) exp_q.push_back(b[i]);
            occ += b.size();
        end else begin
            exp_ovf++;
        end
    endtask

    task automatic send(input logic pressed, input logic ext, input logic [7:0] code);
        key[9:0] = {pressed, ext, code};
        key[10]  = ~key[10];
        model_event(key[9:0]);
    endtask

    // ---------------- line monitor ----------------
    int         nb = 0, hi_run = 0, frames = 0, ovf_seen = 0;
    int         t_start = 0, t_end = 0;
    int         t_starts[$];
    logic       pars[$];
    logic       pclk = 1'b1, frame_act = 1'b0;
    logic [10:0] sh;

    always @(negedge clk) begin
        if (!rst_n) begin
            nb = 0; hi_run = 0; pclk = 1'b1; frame_act = 1'b0;
        end else begin
            if (ps2_clk) hi_run++; else hi_run = 0;
            if (frame_act && ps2_clk && ps2_data && hi_run > C + 1) begin
                nb = 0; frame_act = 1'b0;
            end
            if (!frame_act && ps2_clk && !ps2_data) begin
                frame_act = 1'b1; t_start = cyc;
            end
            if (pclk && !ps2_clk && nb < 11) begin
                sh[nb] = ps2_data; nb++;
            end
            if (!ps2_clk && nb > 0) check_val("data_stable", ps2_data, sh[nb-1]);
            if (!pclk && ps2_clk && nb == 11) begin
                check_val("frame_len", cyc - t_start, 22 * C);
                check_val("start_bit", sh[0], 1'b0);
                check_val("stop_bit", sh[10], 1'b1);
                check_val("odd_parity", $countones(sh[9:1]) % 2, 1);
                if (exp_q.size() == 0) check_val("unexpected_frame", sh[8:1], 32'hFFFF_FFFF);
                else check_val("byte", sh[8:1], exp_q.pop_front());
                occ--;
                t_starts.push_back(t_start);
                pars.push_back(sh[9]);
                frames++; t_end = cyc; nb = 0; frame_act = 1'b0;
            end
            pclk = ps2_clk;
            if (overflow) ovf_seen++;
        end
    end

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_idle"}, busy, 1'b0);
        check_val({tag, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int f0, o0, eo0, ns, n;
        rst_n = 1'b0;
        key   = {$urandom_range(1, 0) == 1, 10'h000};
`ifdef PS2_KEY_TX_INHIBIT_EN
        inh = 1'b0;
`endif
        repeat (4) @(negedge clk);
        check_val("rst_clk", ps2_clk, 1'b1);
        check_val("rst_data", ps2_data, 1'b1);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_ovf", overflow, 1'b0);
        step(1);
        rst_n = 1'b1;
        step(20);
        check_val("no_spurious_busy", busy, 1'b0);
        check_val("no_spurious_frame", frames, 0);

        // single press 0x1C, then the gap before busy drops
        send(1'b1, 1'b0, 8'h1C);
        wait_idle("press1c");
        check_val("press1c_frames", frames, 1);
        check_val("press1c_parity", pars[$], 1'b0);
        check_val("press1c_gap", cyc - t_end, 2 * C);

        // extended release: E0 F0 75 back to back
        f0 = frames;
        send(1'b0, 1'b1, 8'h75);
        wait_idle("extrel");
        check_val("extrel_frames", frames - f0, 3);
        check_val("extrel_par0", pars[pars.size()-3], 1'b0);
        check_val("extrel_par1", pars[pars.size()-2], 1'b1);
        check_val("extrel_par2", pars[pars.size()-1], 1'b0);
        check_val("b2b_space0", t_starts[t_starts.size()-2] - t_starts[t_starts.size()-3], 24 * C + 1);
        check_val("b2b_space1", t_starts[t_starts.size()-1] - t_starts[t_starts.size()-2], 24 * C + 1);

        // fill to 6 of 8, then a 3-byte event must be dropped whole
        o0 = ovf_seen; eo0 = exp_ovf;
        send(1'b0, 1'b1, 8'h11); step(6);
        send(1'b0, 1'b1, 8'h22); step(6);
        send(1'b1, 1'b0, 8'h33); step(6);
        send(1'b0, 1'b1, 8'h44); step(6);
        check_val("ovf_model", exp_ovf - eo0, 1);
        check_val("ovf_pulses", ovf_seen - o0, exp_ovf - eo0);
        send(1'b1, 1'b0, 8'h55); step(6);
        check_val("ovf_after_accept", ovf_seen - o0, 1);
        wait_idle("overflow");

        // two toggles one and two cycles apart
        send(1'b1, 1'b1, 8'hA1); step(1);
        send(1'b0, 1'b0, 8'hB2);
        wait_idle("pair1");
        send(1'b1, 1'b1, 8'hC3); step(2);
        send(1'b0, 1'b0, 8'hD4);
        wait_idle("pair2");

        // reset in the middle of bit 5
        send(1'b1, 1'b0, 8'h5A);
        n = 0;
        while (!(nb == 5 && ps2_clk) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_val("reach_bit5", n < 2000, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_clk", ps2_clk, 1'b1);
        check_val("async_rst_data", ps2_data, 1'b1);
        check_val("async_rst_busy", busy, 1'b0);
        exp_q.delete();
        occ = 0;
        f0 = frames;
        step(3);
        rst_n = 1'b1;
        step(300);
        check_val("post_rst_frames", frames - f0, 0);
        check_val("post_rst_busy", busy, 1'b0);

`ifdef PS2_KEY_TX_INHIBIT_EN
        begin
            int t_rel;
            f0 = frames;
            send(1'b1, 1'b0, 8'h1C);
            n = 0;
            while (!(nb == 3 && ps2_clk) && n < 2000) begin
                @(negedge clk);
                n++;
            end
            check_val("reach_bit3", n < 2000, 1'b1);
            step(1);
            inh = 1'b1;
            step(2);
            check_val("inh_lines_clk", ps2_clk, 1'b1);
            check_val("inh_lines_data", ps2_data, 1'b1);
            step(8);
            inh = 1'b0;
            t_rel = cyc;
            wait_idle("inhibit");
            check_val("inh_frames", frames - f0, 1);
            check_val("inh_restart", t_starts[$] - t_rel, 2 * C);
        end
`endif

        // randomized events, kept clear of overflow
        eo0 = exp_ovf; o0 = ovf_seen;
        for (int i = 0; i < 30; i++) begin
            n = 0;
            while (occ > 2 && n < 3000) begin
                step(1);
                n++;
            end
            if (n >= 3000) check_val("rand_wait", occ, 2);
            send($urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1, 8'($urandom));
            if ($urandom_range(2, 0) == 0) begin
                ns = $urandom_range(2, 1);
                step(ns);
                send($urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1, 8'($urandom));
            end
            step($urandom_range(40, 8));
        end
        wait_idle("random");
        check_val("rand_no_ovf", ovf_seen - o0, exp_ovf - eo0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/ps2_key_tx.md
PS2_KEY_TX -- requirements
Module: ps2_key_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1000: CLK50MHZ cycles per PS/2 clock half-period.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: byte FIFO entries, power of two, minimum 4.
REQ-003 CLK50MHZ  input  1  sole clock; all state on its rising edge.
REQ-004 COCO_RESET_N  input  1  asynchronous assert, active-low reset.
REQ-005 ps2_key  input  11  key event: [10] toggle (new event on any change), [9] pressed, [8] extended, [7:0] scancode.
REQ-006 ps2_clk  output  1  PS/2 clock toward the keyboard receiver, idle high.
REQ-007 ps2_data  output  1  PS/2 data toward the keyboard receiver, idle high.
REQ-008 busy  output  1  high while the FIFO is non-empty or a frame/gap is in progress.
REQ-009 overflow  output  1  one-cycle pulse when an event is dropped.

Function
REQ-010 SHALL register ps2_key[10] and detect an event on any toggle change, one event per change.
REQ-011 Each event SHALL expand to bytes in order: 0xE0 if [8]=1; 0xF0 if [9]=0; then [7:0]. Length is 1 to 3 bytes.
REQ-012 An event SHALL be enqueued atomically: all of its bytes are written when free entries >= its length, otherwise none are written and overflow pulses.
REQ-013 Enqueue SHALL complete within 3 cycles of detection; a second toggle during enqueue SHALL be latched and handled afterwards, not lost.
REQ-014 The transmit FSM SHALL have states IDLE, LOAD, BIT_HI, BIT_LO, GAP.
REQ-015 IDLE -> LOAD when the FIFO is non-empty; LOAD pops one byte and builds the 11-bit frame: start 0, data LSB first, odd parity, stop 1.
REQ-016 In BIT_HI, ps2_data SHALL present the current bit while ps2_clk is high for CLK_DIV cycles.
REQ-017 In BIT_LO, ps2_clk SHALL be low for CLK_DIV cycles with ps2_data held stable.
REQ-018 After 11 bits the FSM SHALL go to GAP, with both lines high for 2*CLK_DIV cycles, then return to IDLE.
REQ-019 Frame length SHALL be exactly 22*CLK_DIV cycles; byte-start to byte-start SHALL be 24*CLK_DIV+1 cycles when queued back to back.
REQ-020 The FIFO SHALL use wrapping read/write pointers one bit wider than the address. Full = MSBs differ and lower bits equal; empty = pointers equal. A simultaneous push and pop SHALL be legal.
REQ-021 The parity bit SHALL be the XNOR-reduction of the data byte.

Reset
REQ-022 While COCO_RESET_N is low: ps2_clk=1, ps2_data=1, busy=0, overflow=0, FIFO empty, FSM in IDLE, toggle register loaded from ps2_key[10] on the first clock after release, so no spurious event.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately, with the lines high in the same cycle (asynchronous). The partial byte is discarded.

Configuration
REQ-024 Macro PS2_KEY_TX_INHIBIT_EN SHALL add input ps2_inhibit (1 bit, host holding clock low).
REQ-025 With the macro: IDLE/LOAD SHALL not start a frame while ps2_inhibit=1. Inhibit seen before the 10th bit's BIT_LO ends SHALL abort the frame with lines high; the same byte is retransmitted after inhibit clears plus a 2*CLK_DIV gap. Inhibit seen later SHALL not affect the frame.
REQ-026 Without the macro the port SHALL not exist and frames SHALL never be held or aborted.

Structure
REQ-027 Package ps2_tx_pkg SHALL hold the FSM state enum and the constants PS2_EXT=8'hE0, PS2_BRK=8'hF0 and FRAME_BITS=11.
REQ-028 The byte FIFO SHALL be sub-module ps2_tx_fifo (parameter FIFO_DEPTH, 8-bit data, push/pop/full/empty/free-count).

Verification (CLK_DIV=4 for speed)
REQ-029 Press 0x1C (toggle, [9]=1, [8]=0): one frame with bits 0,0,0,1,1,1,0,0,0,0,1 (parity 0), 88 cycles, then a 8-cycle gap, busy low after.
REQ-030 Extended release 0x75 ([9]=0, [8]=1): frames 0xE0, 0xF0, 0x75 in order, parity bits 0, 1, 0.
REQ-031 Fill the FIFO to 6 of 8 with DEPTH=8, then an extended release (3 bytes): overflow pulses once, no bytes enqueued; then a 1-byte press is accepted.
REQ-032 Assert COCO_RESET_N=0 during bit 5 of a frame: both lines go high asynchronously, busy=0; after release no frame is emitted and ps2_key is unchanged.
REQ-033 Toggle twice within 2 cycles: both events are transmitted, in order.
REQ-034 With PS2_KEY_TX_INHIBIT_EN, inhibit during bit 3 of 0x1C: abort; after release plus 8 cycles the full 0x1C frame is resent.
